// File: rtl/fpu_arbiter.sv
// fpu_arbiter
//   Round-robin arbiter and sequencer sharing one free-running fpu adder
//   between N requesters. The winner's operands are latched onto the fpu
//   inputs and held for WAIT_CYCLES cycles. The fpu result and status are
//   then captured and returned with a one-cycle ack pulse.
//
// Parameters
//   N            number of requesters (2..8)
//   WAIT_CYCLES  settle cycles before capture. Must be at least 3x the
//                worst-case fpu pass length: the in-flight pass plus two
//                full passes on the new operands.
//
// Ports
//   clock100KHz  system clock, rising edge
//   reset        asynchronous active-low reset
//   req          req[i] high = requester i wants an operation, held to ack[i]
//   op_a_flat    operand A of requester i at bits [32i+31:32i]
//   op_b_flat    operand B of requester i at bits [32i+31:32i]
//   gnt          one-hot owner of the fpu
//   ack          one-cycle completion pulse for requester i
//   result_out   captured fpu data, valid from ack until the next capture
//   status_out   captured fpu status flags
//   busy         high in every state except IDLE
//   fpu_op_a/b   drive the fpu operand inputs
//   fpu_data     fpu data output
//   fpu_status   fpu status output
module fpu_arbiter #(
  parameter int N           = 4,
  parameter int WAIT_CYCLES = 128
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [32*N-1:0]  op_a_flat,
  input  logic [32*N-1:0]  op_b_flat,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic [31:0]      result_out,
  output logic [3:0]       status_out,
  output logic             busy,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  input  logic [31:0]      fpu_data,
  input  logic [3:0]       fpu_status
);

  localparam int IW = $clog2(N);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;   // last requester served
  logic [IW-1:0]   idx;   // requester currently owning the fpu

  logic [31:0]     op_a_arr [N];
  logic [31:0]     op_b_arr [N];

  logic            win_valid;
  logic [IW-1:0]   win_idx;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign op_a_arr[i] = op_a_flat[32*i +: 32];
    assign op_b_arr[i] = op_b_flat[32*i +: 32];
  end

  // Round-robin pick: first set req scanning ptr+1, ptr+2, ... modulo N.
  // The loop runs from the farthest offset to the nearest so the nearest
  // pending requester overwrites any farther one.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a
    // latch is inferred for the no-request case.
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        win_valid = 1'b1;
        win_idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create races.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= IW'(N - 1);
      idx        <= '0;
      gnt        <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      result_out <= '0;
      status_out <= '0;
      fpu_op_a   <= '0;
      fpu_op_b   <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          // With no request the fpu operands keep their last values.
          if (win_valid) begin
            idx      <= win_idx;
            gnt      <= N'(1) << win_idx;
            fpu_op_a <= op_a_arr[win_idx];
            fpu_op_b <= op_b_arr[win_idx];
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Operands are not re-sampled here; later requester changes are
          // ignored until the next grant.
          if (cnt == CNT_LAST) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: begin
          result_out <= fpu_data;
          status_out <= fpu_status;
          ack        <= N'(1) << idx;
          ptr        <= idx;
          gnt        <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
